controlador_sequenciador: RTL and testbench



---
 rtl/sap1_pkg.sv | 37 +++
 rtl/contador_anel_6.sv | 43 ++++
 rtl/controlador_sequenciador.sv | 101 ++++++++++
 tb/tb_controlador_sequenciador.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot sequencer states and control-word layout.
package sap1_pkg;

  localparam logic [3:0] OpLda = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpOut = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  // Bits 5:0 are the T1..T6 ring; bit 6 marks HALT so t_state reads zero there.
  typedef enum logic [6:0] {
    StT1   = 7'b0000001,
    StT2   = 7'b0000010,
    StT3   = 7'b0000100,
    StT4   = 7'b0001000,
    StT5   = 7'b0010000,
    StT6   = 7'b0100000,
    StHalt = 7'b1000000
  } state_e;

  localparam int unsigned CwWidth = 12;
  localparam int unsigned CwCp    = 0;
  localparam int unsigned CwEp    = 1;
  localparam int unsigned CwLm    = 2;
  localparam int unsigned CwCe    = 3;
  localparam int unsigned CwLi    = 4;
  localparam int unsigned CwEi    = 5;
  localparam int unsigned CwLa    = 6;
  localparam int unsigned CwEa    = 7;
  localparam int unsigned CwSu    = 8;
  localparam int unsigned CwEu    = 9;
  localparam int unsigned CwLb    = 10;
  localparam int unsigned CwLo    = 11;

  typedef logic [CwWidth-1:0] ctrl_word_t;

endpackage

// File: rtl/contador_anel_6.sv
// Six-state one-hot ring counter with hold (run), HALT entry (stop) and synchronous clear.
module contador_anel_6
  import sap1_pkg::*;
(
  input  logic   clock,
  input  logic   clear,
  input  logic   run,
  input  logic   stop,
  output state_e state
);

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (run && (state_q != StHalt)) begin
      if (stop) begin
        state_d = StHalt;
      end else begin
        unique case (state_q)
          StT1:    state_d = StT2;
          StT2:    state_d = StT3;
          StT3:    state_d = StT4;
          StT4:    state_d = StT5;
          StT5:    state_d = StT6;
          StT6:    state_d = StT1;
          default: state_d = StT1;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StT1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/controlador_sequenciador.sv
// SAP-1 controller/sequencer: ring counter plus combinational decode of state and opcode.
module controlador_sequenciador
  import sap1_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       halt,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo
);

  state_e     state;
  logic       stop;
  ctrl_word_t cw;

  assign stop = (state == StT4) && (opcode == OpHlt);

  contador_anel_6 u_ring (
    .clock (clock),
    .clear (clear),
    .run   (run),
    .stop  (stop),
    .state (state)
  );

  always_comb begin
    cw = '0;
    unique case (state)
      StT1: begin
        cw[CwEp] = 1'b1;
        cw[CwLm] = 1'b1;
      end
      StT2: cw[CwCp] = 1'b1;
      StT3: begin
        cw[CwCe] = 1'b1;
        cw[CwLi] = 1'b1;
      end
      StT4: begin
        if (opcode == OpLda || opcode == OpAdd || opcode == OpSub) begin
          cw[CwEi] = 1'b1;
          cw[CwLm] = 1'b1;
        end else if (opcode == OpOut) begin
          cw[CwEa] = 1'b1;
          cw[CwLo] = 1'b1;
        end
      end
      StT5: begin
        if (opcode == OpLda) begin
          cw[CwCe] = 1'b1;
          cw[CwLa] = 1'b1;
        end else if (opcode == OpAdd || opcode == OpSub) begin
          cw[CwCe] = 1'b1;
          cw[CwLb] = 1'b1;
        end
      end
      StT6: begin
        if (opcode == OpAdd || opcode == OpSub) begin
          cw[CwEu] = 1'b1;
          cw[CwLa] = 1'b1;
          cw[CwSu] = (opcode == OpSub);
        end
      end
      StHalt:  cw = '0;
      default: cw = '0;
    endcase
    // Paused sequencer must not repeat strobes while the state is held.
    if (!run) begin
      cw = '0;
    end
  end

  assign t_state = state[5:0];
  assign halt    = (state == StHalt);

  assign cp = cw[CwCp];
  assign ep = cw[CwEp];
  assign lm = cw[CwLm];
  assign ce = cw[CwCe];
  assign li = cw[CwLi];
  assign ei = cw[CwEi];
  assign la = cw[CwLa];
  assign ea = cw[CwEa];
  assign su = cw[CwSu];
  assign eu = cw[CwEu];
  assign lb = cw[CwLb];
  assign lo = cw[CwLo];

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Bench for the SAP-1 sequencer: directed vector table, corner sequences, random vs. model.
module tb_controlador_sequenciador;

  logic       clock;
  logic       clear;
  logic       run;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       halt;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

  // Bench-local control word packing, MSB first: cp ep lm ce li ei la ea su eu lb lo.
  localparam logic [11:0] Cp = 12'b1000_0000_0000;
  localparam logic [11:0] Ep = 12'b0100_0000_0000;
  localparam logic [11:0] Lm = 12'b0010_0000_0000;
  localparam logic [11:0] Ce = 12'b0001_0000_0000;
  localparam logic [11:0] Li = 12'b0000_1000_0000;
  localparam logic [11:0] Ei = 12'b0000_0100_0000;
  localparam logic [11:0] La = 12'b0000_0010_0000;
  localparam logic [11:0] Ea = 12'b0000_0001_0000;
  localparam logic [11:0] Su = 12'b0000_0000_1000;
  localparam logic [11:0] Eu = 12'b0000_0000_0100;
  localparam logic [11:0] Lb = 12'b0000_0000_0010;
  localparam logic [11:0] Lo = 12'b0000_0000_0001;
  localparam logic [11:0] None = 12'b0;

  typedef struct {
    logic       clr;
    logic       rn;
    logic [3:0] op;
    bit         chk;
    logic [5:0] t;
    logic       h;
    logic [11:0] cw;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Micro-program tables for the reference model.
  logic [11:0] fetch_tbl [3];
  logic [11:0] exec_tbl  [16][3];
  int          m_phase;
  bit          m_halt;

  wire [11:0] dut_cw = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

  controlador_sequenciador dut (
    .clock   (clock),
    .clear   (clear),
    .run     (run),
    .opcode  (opcode),
    .t_state (t_state),
    .halt    (halt),
    .cp      (cp),
    .ep      (ep),
    .lm      (lm),
    .ce      (ce),
    .li      (li),
    .ei      (ei),
    .la      (la),
    .ea      (ea),
    .su      (su),
    .eu      (eu),
    .lb      (lb),
    .lo      (lo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t v(logic c, logic r, logic [3:0] o, bit chk, logic [5:0] t, logic h,
                             logic [11:0] cw);
    vec_t x;
    x.clr = c; x.rn = r; x.op = o; x.chk = chk; x.t = t; x.h = h; x.cw = cw;
    return x;
  endfunction

  function automatic logic [5:0] tph(int k);
    logic [5:0] one;
    one = 6'b000001;
    return one << k;
  endfunction

  task automatic add_instr(input logic [3:0] o, input logic [11:0] e4, input logic [11:0] e5,
                           input logic [11:0] e6);
    tbl.push_back(v(1'b0, 1'b1, o, 1'b1, tph(0), 1'b0, Ep | Lm));
    tbl.push_back(v(1'b0, 1'b1, o, 1'b1, tph(1), 1'b0, Cp));
    tbl.push_back(v(1'b0, 1'b1, o, 1'b1, tph(2), 1'b0, Ce | Li));
    tbl.push_back(v(1'b0, 1'b1, o, 1'b1, tph(3), 1'b0, e4));
    tbl.push_back(v(1'b0, 1'b1, o, 1'b1, tph(4), 1'b0, e5));
    tbl.push_back(v(1'b0, 1'b1, o, 1'b1, tph(5), 1'b0, e6));
  endtask

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got t_state=%b halt=%b ctrl=%b, expected t_state=%b halt=%b ctrl=%b",
               name, got[18:13], got[12], got[11:0], exp[18:13], exp[12], exp[11:0]);
    end
  endtask

  task automatic check_bus(input string name);
    int drivers;
    drivers = $countones({ep, ce, ei, ea, eu});
    n_checks++;
    if (drivers > 1) begin
      n_fail++;
      $display("FAIL %s bus_exclusive: got %0d bus drivers, expected at most 1", name, drivers);
    end
  endtask

  // Drive one cycle's inputs mid-low-phase, then compare before the next rising edge.
  task automatic apply(input logic c, input logic r, input logic [3:0] o, input bit chk,
                       input logic [5:0] et, input logic eh, input logic [11:0] ecw,
                       input string name);
    @(negedge clock);
    clear  = c;
    run    = r;
    opcode = o;
    #1;
    if (chk) begin
      check(name, {t_state, halt, dut_cw}, {et, eh, ecw});
      check_bus(name);
    end
  endtask

  initial begin
    logic       rc, rr;
    logic [3:0] ro;
    logic [5:0] et;
    logic       eh;
    logic [11:0] ecw;

    clear  = 1'b1;
    run    = 1'b1;
    opcode = 4'h0;

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 3; k++) exec_tbl[i][k] = None;
    end
    fetch_tbl[0] = Ep | Lm;
    fetch_tbl[1] = Cp;
    fetch_tbl[2] = Ce | Li;
    exec_tbl[4'h0][0] = Ei | Lm; exec_tbl[4'h0][1] = Ce | La;
    exec_tbl[4'h1][0] = Ei | Lm; exec_tbl[4'h1][1] = Ce | Lb; exec_tbl[4'h1][2] = Eu | La;
    exec_tbl[4'h2][0] = Ei | Lm; exec_tbl[4'h2][1] = Ce | Lb; exec_tbl[4'h2][2] = Eu | La | Su;
    exec_tbl[4'hE][0] = Ea | Lo;

    // Directed table: LDA, ADD, SUB, OUT, NOP(0101), then wrap to T1.
    tbl.push_back(v(1'b1, 1'b1, 4'h0, 1'b0, 6'b0, 1'b0, None));
    add_instr(4'h0, Ei | Lm, Ce | La, None);
    add_instr(4'h1, Ei | Lm, Ce | Lb, Eu | La);
    add_instr(4'h2, Ei | Lm, Ce | Lb, Eu | La | Su);
    add_instr(4'hE, Ea | Lo, None, None);
    add_instr(4'h5, None, None, None);
    tbl.push_back(v(1'b0, 1'b1, 4'h0, 1'b1, tph(0), 1'b0, Ep | Lm));
    foreach (tbl[i]) begin
      apply(tbl[i].clr, tbl[i].rn, tbl[i].op, tbl[i].chk, tbl[i].t, tbl[i].h, tbl[i].cw,
            $sformatf("table[%0d]", i));
    end

    // HLT: halt holds regardless of run/opcode until clear.
    apply(1'b1, 1'b1, 4'hF, 1'b0, 6'b0, 1'b0, None, "hlt_clr");
    apply(1'b0, 1'b1, 4'hF, 1'b1, tph(0), 1'b0, Ep | Lm, "hlt_t1");
    apply(1'b0, 1'b1, 4'hF, 1'b1, tph(1), 1'b0, Cp, "hlt_t2");
    apply(1'b0, 1'b1, 4'hF, 1'b1, tph(2), 1'b0, Ce | Li, "hlt_t3");
    apply(1'b0, 1'b1, 4'hF, 1'b1, tph(3), 1'b0, None, "hlt_t4");
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)), 1'b1, 6'b0, 1'b1, None,
            $sformatf("halted[%0d]", i));
    end
    apply(1'b1, 1'b0, 4'h3, 1'b1, 6'b0, 1'b1, None, "halt_clear_cycle");
    apply(1'b0, 1'b1, 4'h0, 1'b1, tph(0), 1'b0, Ep | Lm, "halt_exit_t1");

    // Pause in T2: no repeated cp, then exactly one cp on resume.
    apply(1'b1, 1'b1, 4'h0, 1'b0, 6'b0, 1'b0, None, "pause_clr");
    apply(1'b0, 1'b1, 4'h0, 1'b1, tph(0), 1'b0, Ep | Lm, "pause_t1");
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 4'h0, 1'b1, tph(1), 1'b0, None, $sformatf("paused_t2[%0d]", i));
    end
    apply(1'b0, 1'b1, 4'h0, 1'b1, tph(1), 1'b0, Cp, "resume_t2");
    apply(1'b0, 1'b1, 4'h0, 1'b1, tph(2), 1'b0, Ce | Li, "resume_t3");

    // Clear mid-instruction (T5 of ADD) restarts at T1 without a second lb.
    apply(1'b1, 1'b1, 4'h1, 1'b0, 6'b0, 1'b0, None, "midclr_clr");
    apply(1'b0, 1'b1, 4'h1, 1'b1, tph(0), 1'b0, Ep | Lm, "midclr_t1");
    apply(1'b0, 1'b1, 4'h1, 1'b1, tph(1), 1'b0, Cp, "midclr_t2");
    apply(1'b0, 1'b1, 4'h1, 1'b1, tph(2), 1'b0, Ce | Li, "midclr_t3");
    apply(1'b0, 1'b1, 4'h1, 1'b1, tph(3), 1'b0, Ei | Lm, "midclr_t4");
    apply(1'b1, 1'b1, 4'h1, 1'b1, tph(4), 1'b0, Ce | Lb, "midclr_t5");
    apply(1'b0, 1'b1, 4'h1, 1'b1, tph(0), 1'b0, Ep | Lm, "midclr_after_t1");
    apply(1'b0, 1'b1, 4'h1, 1'b1, tph(1), 1'b0, Cp, "midclr_after_t2");

    // Random run/opcode/clear against the phase-counter model.
    apply(1'b1, 1'b1, 4'h0, 1'b0, 6'b0, 1'b0, None, "rand_clr");
    m_phase = 0;
    m_halt  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(24) == 0);
      rr = ($urandom_range(3) != 0);
      ro = 4'($urandom_range(15));
      if (m_halt) begin
        et = 6'b0; eh = 1'b1; ecw = None;
      end else begin
        et  = tph(m_phase);
        eh  = 1'b0;
        ecw = !rr ? None : (m_phase < 3) ? fetch_tbl[m_phase] : exec_tbl[ro][m_phase - 3];
      end
      apply(rc, rr, ro, 1'b1, et, eh, ecw, $sformatf("rand[%0d]", i));
      if (rc) begin
        m_phase = 0;
        m_halt  = 1'b0;
      end else if (!m_halt && rr) begin
        if (m_phase == 3 && ro == 4'hF) m_halt = 1'b1;
        else m_phase = (m_phase + 1) % 6;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
